// File: rtl/lcd_pkg.sv
// Purpose : shared types and helpers for the LCD bus arbiter.
// Latency : n/a (package).
// Backpressure: n/a (package).
// Contents: FSM state enum, default E-strobe timing, width helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_ACK
  } lcd_state_e;

  localparam int LCD_SETUP_CYC_DEF = 2;
  localparam int LCD_PULSE_CYC_DEF = 12;
  localparam int LCD_HOLD_CYC_DEF  = 2;

  // Grant index width: at least one bit even for two channels.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Phase counter width: must hold the longest phase length.
  function automatic int cnt_w(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Purpose : pick one requesting channel, round-robin from ptr_i or fixed lowest-index.
// Latency : purely combinational, zero cycles.
// Backpressure: none; losers simply see no grant and keep requesting.
// Ports   : req_i (level requests), ptr_i (RR start point), gnt_o (one-hot), idx_o (winner index).
module lcd_rr_arb
  import lcd_pkg::*;
#(
  parameter int  NUM_CH = 2,
  parameter int  RR_EN  = 1,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o
);

  logic found;
  int   pos;

  // Walk priority slots in order; slot k maps to channel (ptr+k) mod N in
  // round-robin mode, or to channel k in fixed mode. First requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = (RR_EN != 0) ? (int'(ptr_i) + k) % NUM_CH : k;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req_i[i] && (i == pos)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = CH_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Purpose : arbitrate NUM_CH writers onto one HD44780 bus, strobe E, ack the winner.
// Latency : grant at end of cycle t; E high t+1+SETUP..t+SETUP+PULSE; ack at t+1+SETUP+PULSE+HOLD.
// Backpressure: losing channels hold req until granted; busy is high grant..ack inclusive.
// Ports   : req/rsIn/dIn per channel in; ack per channel, dOut/rsOut/lcdE bus, busy, grantIdx out.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int  NUM_CH    = 2,
  parameter int  DATA_W    = 8,
  parameter int  SETUP_CYC = LCD_SETUP_CYC_DEF,
  parameter int  PULSE_CYC = LCD_PULSE_CYC_DEF,
  parameter int  HOLD_CYC  = LCD_HOLD_CYC_DEF,
  parameter int  RR_EN     = 1,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        rsIn,
  input  logic [NUM_CH*DATA_W-1:0] dIn,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        dOut,
  output logic                     rsOut,
  output logic                     lcdE,
  output logic                     busy,
  output logic [CH_W-1:0]          grantIdx
);

  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("lcd_bus_arbiter: NUM_CH must be >= 2");
  end
  if (DATA_W != 8 && DATA_W != 4) begin : g_bad_data_w
    $error("lcd_bus_arbiter: DATA_W must be 8 or 4");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("lcd_bus_arbiter: PULSE_CYC must be >= 1");
  end

  localparam int CNT_W = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  // Counter is loaded with (length-1) on phase entry and the phase ends at 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  lcd_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     ptr_q;
  logic [CH_W-1:0]     gidx_q;
  logic [NUM_CH-1:0]   ack_q;
  logic [DATA_W-1:0]   dout_q;
  logic                rs_q;
  logic                lcde_q;
  logic                busy_q;

  logic [NUM_CH-1:0]   gnt_oh;
  logic [CH_W-1:0]     gnt_idx;
  logic [DATA_W-1:0]   win_dat_d;
  logic                win_rs_d;

  lcd_rr_arb #(
    .NUM_CH (NUM_CH),
    .RR_EN  (RR_EN)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx)
  );

  // Select the winner's data/RS with the one-hot grant.
  always_comb begin
    win_dat_d = '0;
    win_rs_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) begin
        win_dat_d = dIn[i*DATA_W +: DATA_W];
        win_rs_d  = rsIn[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      ack_q   <= '0;
      dout_q  <= '0;
      rs_q    <= 1'b0;
      lcde_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            dout_q <= win_dat_d;
            rs_q   <= win_rs_d;
            gidx_q <= gnt_idx;
            busy_q <= 1'b1;
            if (SETUP_CYC > 0) begin
              state_q <= ST_SETUP;
              cnt_q   <= SETUP_LD;
            end else begin
              state_q <= ST_PULSE;
              cnt_q   <= PULSE_LD;
              lcde_q  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_PULSE;
            cnt_q   <= PULSE_LD;
            lcde_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            lcde_q <= 1'b0;
            if (HOLD_CYC > 0) begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LD;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= NUM_CH'(1) << gidx_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_ACK;
            ack_q   <= NUM_CH'(1) << gidx_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          // Next search starts just above the channel that was served.
          ptr_q   <= (gidx_q == CH_W'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          lcde_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign dOut     = dout_q;
  assign rsOut    = rs_q;
  assign lcdE     = lcde_q;
  assign busy     = busy_q;
  assign grantIdx = gidx_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Purpose : self-checking bench for lcd_bus_arbiter (three configurations).
// Latency : checks outputs cycle by cycle on the falling clock edge.
// Backpressure: exercises held, dropped and competing requests.
module tb_lcd_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults, 2 channels, round-robin.
  logic        rst_a;
  logic [1:0]  req_a, rs_a, ack_a;
  logic [15:0] d_a;
  logic [7:0]  dout_a;
  logic        rso_a, e_a, busy_a;
  logic [0:0]  gi_a;

  lcd_bus_arbiter #(.NUM_CH(2)) u_def (
    .clk(clk), .rst(rst_a), .req(req_a), .rsIn(rs_a), .dIn(d_a), .ack(ack_a),
    .dOut(dout_a), .rsOut(rso_a), .lcdE(e_a), .busy(busy_a), .grantIdx(gi_a));

  // Instance B: fixed priority, zero setup/hold, one-cycle pulse.
  logic        rst_o;
  logic [1:0]  req_b, rs_b, ack_b;
  logic [15:0] d_b;
  logic [7:0]  dout_b;
  logic        rso_b, e_b, busy_b;
  logic [0:0]  gi_b;

  lcd_bus_arbiter #(.NUM_CH(2), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0), .RR_EN(0)) u_fz (
    .clk(clk), .rst(rst_o), .req(req_b), .rsIn(rs_b), .dIn(d_b), .ack(ack_b),
    .dOut(dout_b), .rsOut(rso_b), .lcdE(e_b), .busy(busy_b), .grantIdx(gi_b));

  // Instance C: 3 channels, 4-bit bus, short timing, random traffic.
  logic [2:0]  req_c, rs_c, ack_c;
  logic [11:0] d_c;
  logic [3:0]  dout_c;
  logic        rso_c, e_c, busy_c;
  logic [1:0]  gi_c;

  lcd_bus_arbiter #(.NUM_CH(3), .DATA_W(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .RR_EN(1)) u_rnd (
    .clk(clk), .rst(rst_o), .req(req_c), .rsIn(rs_c), .dIn(d_c), .ack(ack_c),
    .dOut(dout_c), .rsOut(rso_c), .lcdE(e_c), .busy(busy_c), .grantIdx(gi_c));

  function automatic logic [31:0] v2(input logic [7:0] d, input logic rs, input logic e,
                                     input logic [1:0] ak, input logic bz, input logic gi);
    return {18'b0, d, rs, e, ak, bz, gi};
  endfunction

  function automatic logic [31:0] v3(input logic [3:0] d, input logic rs, input logic e,
                                     input logic [2:0] ak, input logic bz, input logic [1:0] gi);
    return {20'b0, d, rs, e, ak, bz, gi};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (d,rs,e,ack,busy,gi)", name, act, exp);
    end
  endtask

  // Follows one default-timing transaction granted in the current cycle:
  // cycles k=1..17 are busy, E is high k=3..14, ack at k=17, k=18 is idle.
  task automatic watch_a(input int ch, input logic [7:0] d, input logic rs,
                         input logic [1:0] next_req, input bit poke);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk($sformatf("def_ch%0d_k%0d", ch, k),
          v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]),
          v2(d, rs, (k >= 3 && k <= 14), (k == 17) ? (2'b01 << ch) : 2'b00, (k <= 17), ch[0]));
      if (poke && k == 5) d_a[ch*8 +: 8] = 8'hFF;
      if (k == 17) req_a = next_req;
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rs;
    logic [15:0] d;
    logic [7:0]  e_d;
    logic        e_rs;
    logic        e_e;
    logic [1:0]  e_ack;
    logic        e_busy;
    logic        e_gi;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int  tg, ptr, win, hgi;
    int  S, P, T;
    bit  act, found;
    logic [3:0] hd;
    logic       hrs;

    // Per row: inputs driven this cycle, outputs expected this cycle.
    tbl[0]  = '{2'b01, 2'b00, 16'hAA38, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 2'b00, 16'h1122, 8'h38, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{2'b11, 2'b10, 16'h4130, 8'h38, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{2'b11, 2'b10, 16'h4130, 8'h38, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{2'b11, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{2'b10, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 2'b10, 16'h4130, 8'h30, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 2'b10, 16'h4130, 8'h41, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[11] = '{2'b00, 2'b10, 16'h4130, 8'h41, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1};
    tbl[12] = '{2'b00, 2'b10, 16'h4130, 8'h41, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1};

    rst_a = 1'b1; rst_o = 1'b1;
    req_a = '0; rs_a = '0; d_a = '0;
    req_b = '0; rs_b = '0; d_b = '0;
    req_c = '0; rs_c = '0; d_c = '0;
    #1;
    chk("reset_a", v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]), v2(8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    chk("reset_c", v3(dout_c, rso_c, e_c, ack_c, busy_c, gi_c), v3(4'h0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0));
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_o = 1'b0;

    // Single write on channel 1.
    @(negedge clk);
    req_a = 2'b10; rs_a = 2'b10; d_a = 16'h4100;
    watch_a(1, 8'h41, 1'b1, 2'b00, 1'b0);

    // Both channels held: round-robin alternates 0,1,0,1 with acks 18 apart.
    @(negedge clk);
    req_a = 2'b11; rs_a = 2'b01; d_a = 16'hB1A0;
    watch_a(0, 8'hA0, 1'b1, 2'b11, 1'b0);
    watch_a(1, 8'hB1, 1'b0, 2'b11, 1'b0);
    watch_a(0, 8'hA0, 1'b1, 2'b11, 1'b0);
    watch_a(1, 8'hB1, 1'b0, 2'b00, 1'b0);

    // Data changes during PULSE must not reach dOut.
    @(negedge clk);
    req_a = 2'b01; rs_a = 2'b00; d_a = 16'h0038;
    watch_a(0, 8'h38, 1'b0, 2'b00, 1'b1);

    // Reset mid-pulse. Pointer now 1, so channel 1 wins first.
    @(negedge clk);
    req_a = 2'b11; rs_a = 2'b10; d_a = 16'h5566;
    repeat (5) @(negedge clk);
    chk("pre_reset_pulse", v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]), v2(8'h55, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1));
    rst_a = 1'b1;
    #1;
    chk("reset_immediate", v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]), v2(8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("in_reset_%0d", k), v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]), v2(8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    end
    rst_a = 1'b0;
    @(negedge clk);
    chk("regrant_ch0", v2(dout_a, rso_a, e_a, ack_a, busy_a, gi_a[0]), v2(8'h66, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    req_a = 2'b00;

    // Fixed priority / zero setup-hold table.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("fz_row%0d", i), v2(dout_b, rso_b, e_b, ack_b, busy_b, gi_b[0]),
          v2(tbl[i].e_d, tbl[i].e_rs, tbl[i].e_e, tbl[i].e_ack, tbl[i].e_busy, tbl[i].e_gi));
      req_b = tbl[i].req; rs_b = tbl[i].rs; d_b = tbl[i].d;
    end

    // Random traffic against a timeline model: grant at cycle tg means busy
    // for tg+1..tg+T, E for tg+1+S..tg+S+P, ack at tg+T.
    S = 1; P = 2; T = 1 + 1 + 2 + 1;
    tg = -1000; ptr = 0; win = 0; hgi = 0; hd = 4'h0; hrs = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      act = (c > tg) && (c <= tg + T);
      chk($sformatf("rnd_c%0d", c), v3(dout_c, rso_c, e_c, ack_c, busy_c, gi_c),
          v3(hd, hrs, act && (c >= tg + 1 + S) && (c <= tg + S + P),
             (act && c == tg + T) ? 3'(1 << win) : 3'b000, act, 2'(hgi)));
      req_c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req_c = 3'b000;
      rs_c = 3'($urandom);
      d_c  = 12'($urandom);
      if (!act && req_c != 3'b000) begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!found && req_c[(ptr + k) % 3]) begin
            found = 1'b1;
            win   = (ptr + k) % 3;
          end
        end
        tg  = c;
        hd  = d_c[win*4 +: 4];
        hrs = rs_c[win];
        hgi = win;
        ptr = (win + 1) % 3;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
